// File: rtl/spi_frame_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_frame_pkg
//  Description : Shared types and helpers for the SPI frame serializer:
//                FSM state enum, frame-length derivation and the default
//                command / register-address constants of the ESP link.
//  Revision    : 1.0  initial release
// ============================================================================
package spi_frame_pkg;

    // Serializer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Default first byte of a frame (ESP "write registers" command)
    localparam logic [7:0] CMD_WRITE     = 8'h02;
    // Default ESP register address sent as the second byte
    localparam logic [7:0] ESP_BASE_ADDR = 8'h00;

    // Number of bytes in one frame: command + address + payload (+ checksum)
    function automatic int calc_total(input int num_channels,
                                      input int bytes_per_channel,
                                      input int checksum_en);
        return 2 + num_channels * bytes_per_channel + ((checksum_en != 0) ? 1 : 0);
    endfunction

endpackage : spi_frame_pkg
`default_nettype wire

// File: rtl/spi_frame_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_frame_serializer_if
//  Description : Byte handshake between the frame serializer and the SPI
//                slave core.
//                  di_req    : core requests the next byte
//                  write_ack : core acknowledges a byte (rising edge counts)
//                  tx_byte   : byte presented to the core
//                  wren      : tx_byte valid, held until acknowledged
//                master = serializer side, slave = SPI core side.
//  Revision    : 1.0  initial release
// ============================================================================
interface spi_frame_serializer_if;

    logic       di_req;
    logic       write_ack;
    logic [7:0] tx_byte;
    logic       wren;

    modport master (
        input  di_req,
        input  write_ack,
        output tx_byte,
        output wren
    );

    modport slave (
        output di_req,
        output write_ack,
        input  tx_byte,
        input  wren
    );

endinterface : spi_frame_serializer_if
`default_nettype wire

// File: rtl/spi_frame_byte_mux.sv
`default_nettype none
// ============================================================================
//  Module      : spi_frame_byte_mux
//  Description : Combinational payload byte selector. Maps frame byte index
//                k (k=0 command, k=1 address, k>=2 payload) onto the latched
//                frame, honouring the per-word byte order.
//  Ports       : i_frame  latched frame, channel c at [(c+1)*BPC*8-1 : c*BPC*8]
//                i_k      frame byte index
//                o_byte   payload byte for index k (0 outside the payload)
//  Revision    : 1.0  initial release
// ============================================================================
module spi_frame_byte_mux #(
    parameter int NUM_CHANNELS      = 8,
    parameter int BYTES_PER_CHANNEL = 4,
    parameter int MSB_FIRST         = 0,
    parameter int K_W               = 6
) (
    input  wire logic [NUM_CHANNELS*BYTES_PER_CHANNEL*8-1:0] i_frame,
    input  wire logic [K_W-1:0]                              i_k,
    output logic      [7:0]                                  o_byte
);

    localparam int NBYTES = NUM_CHANNELS * BYTES_PER_CHANNEL;

    int w_k;     // index as integer
    int w_p;     // payload byte number
    int w_b;     // byte position within the word, in transmit order
    int w_lane;  // byte lane within the word
    int w_idx;   // flat byte index into the frame vector

    always_comb begin
        w_k    = int'(i_k);
        w_p    = w_k - 2;
        w_b    = 0;
        w_lane = 0;
        w_idx  = 0;
        o_byte = '0;
        if (w_p >= 0 && w_p < NBYTES) begin
            w_b    = w_p % BYTES_PER_CHANNEL;
            w_lane = (MSB_FIRST != 0) ? (BYTES_PER_CHANNEL - 1 - w_b) : w_b;
            // start of this channel's word, then the selected lane
            w_idx  = (w_p - w_b) + w_lane;
            o_byte = i_frame[w_idx*8 +: 8];
        end
    end

endmodule : spi_frame_byte_mux
`default_nettype wire

// File: rtl/spi_frame_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : spi_frame_serializer
//  Description : Latches a frame of NUM_CHANNELS sensor words and streams it
//                to the SPI slave core byte by byte:
//                  CMD_BYTE, START_ADDR, payload, [checksum]
//                The checksum makes START_ADDR + payload + checksum == 0 mod 256.
//  Ports       : clock, reset_n      clock, asynchronous active-low reset
//                i_frame_data        frame to send
//                i_frame_valid       frame offered this cycle
//                o_frame_ready       high while idle (frame accepted on valid)
//                i_abort             synchronous abort of the current frame
//                spi                 byte handshake to the SPI core (master)
//                o_busy              frame in progress
//                o_frame_done        one-cycle pulse after the last acknowledge
//                o_drop_count        saturating count of frames offered busy
//  Revision    : 1.0  initial release
// ============================================================================
module spi_frame_serializer
    import spi_frame_pkg::*;
#(
    parameter int          NUM_CHANNELS      = 8,
    parameter int          BYTES_PER_CHANNEL = 4,
    parameter logic [7:0]  CMD_BYTE          = CMD_WRITE,
    parameter logic [7:0]  START_ADDR        = ESP_BASE_ADDR,
    parameter int          MSB_FIRST         = 0,
    parameter int          CHECKSUM_EN       = 1
) (
    input  wire logic                                        clock,
    input  wire logic                                        reset_n,
    input  wire logic [NUM_CHANNELS*BYTES_PER_CHANNEL*8-1:0] i_frame_data,
    input  wire logic                                        i_frame_valid,
    output logic                                             o_frame_ready,
    input  wire logic                                        i_abort,
    spi_frame_serializer_if.master                           spi,
    output logic                                             o_busy,
    output logic                                             o_frame_done,
    output logic      [7:0]                                  o_drop_count
);

    localparam int FRAME_W = NUM_CHANNELS * BYTES_PER_CHANNEL * 8;
    localparam int TOTAL   = calc_total(NUM_CHANNELS, BYTES_PER_CHANNEL, CHECKSUM_EN);
    localparam int K_W     = $clog2(TOTAL + 1);
    localparam logic [K_W-1:0] LAST_K = K_W'(TOTAL - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [FRAME_W-1:0]   r_frame;
    logic [K_W-1:0]       r_k;
    logic [7:0]           r_sum;
    logic                 r_wack_prev;
    logic [7:0]           r_tx_byte;
    logic                 r_wren;
    logic [7:0]           r_drop;

    logic                 w_ack_edge;
    logic                 w_accept;
    logic                 w_ack;
    logic                 w_load;
    logic [7:0]           w_payload_byte;
    logic [7:0]           w_next_byte;

    // ------------------------------------------------------------------
    // Handshake qualifiers. Abort beats everything in the same cycle; an
    // acknowledge edge in the same cycle as a request suppresses the load
    // so a fresh byte never replaces one that is just being acknowledged.
    // ------------------------------------------------------------------
    assign w_ack_edge = spi.write_ack & ~r_wack_prev;
    assign w_accept   = (r_state == ST_IDLE) & i_frame_valid & ~i_abort;
    assign w_ack      = (r_state == ST_SEND) & r_wren & w_ack_edge & ~i_abort;
    assign w_load     = (r_state == ST_SEND) & spi.di_req & ~r_wren & ~w_ack_edge & ~i_abort;

    spi_frame_byte_mux #(
        .NUM_CHANNELS      (NUM_CHANNELS),
        .BYTES_PER_CHANNEL (BYTES_PER_CHANNEL),
        .MSB_FIRST         (MSB_FIRST),
        .K_W               (K_W)
    ) u_byte_mux (
        .i_frame (r_frame),
        .i_k     (r_k),
        .o_byte  (w_payload_byte)
    );

    // Byte for the current index. The running sum already holds START_ADDR
    // and every payload byte when the checksum slot is reached.
    always_comb begin
        w_next_byte = w_payload_byte;
        if (r_k == '0) begin
            w_next_byte = CMD_BYTE;
        end else if (r_k == K_W'(1)) begin
            w_next_byte = START_ADDR;
        end else if ((CHECKSUM_EN != 0) && (r_k == LAST_K)) begin
            w_next_byte = 8'h00 - r_sum;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        o_frame_ready = 1'b0;
        o_busy        = 1'b0;
        o_frame_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_frame_ready = 1'b1;
                if (w_accept) begin
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                o_busy = 1'b1;
                if (w_ack && (r_k == LAST_K)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_frame_done = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (i_abort) begin
            w_state_next = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_frame     <= '0;
            r_k         <= '0;
            r_sum       <= '0;
            r_wack_prev <= 1'b0;
            r_tx_byte   <= '0;
            r_wren      <= 1'b0;
            r_drop      <= '0;
        end else begin
            r_state     <= w_state_next;
            r_wack_prev <= spi.write_ack;

            // Offers while not ready are counted, abort or not
            if (i_frame_valid && !o_frame_ready && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end

            if (i_abort) begin
                r_wren <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_frame <= i_frame_data;
                    r_k     <= '0;
                    r_sum   <= '0;
                end
                if (w_ack) begin
                    r_wren <= 1'b0;
                    r_k    <= r_k + K_W'(1);
                    // the command byte is outside the checksum
                    if (r_k != '0) begin
                        r_sum <= r_sum + r_tx_byte;
                    end
                end
                if (w_load) begin
                    r_tx_byte <= w_next_byte;
                    r_wren    <= 1'b1;
                end
            end
        end
    end

    assign spi.tx_byte   = r_tx_byte;
    assign spi.wren      = r_wren;
    assign o_drop_count  = r_drop;

endmodule : spi_frame_serializer
`default_nettype wire

// File: tb/tb_spi_frame_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_frame_serializer
//  Description : Self-checking bench for spi_frame_serializer. A queue-based
//                frame model supplies the expected byte stream; a monitor
//                compares every presented byte against it. A second instance
//                with a small MSB-first configuration is checked against a
//                literal byte list.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_frame_serializer;

    localparam int NC  = 8;
    localparam int BPC = 4;
    localparam int FW  = NC * BPC * 8;
    localparam int TOT = 2 + NC * BPC + 1;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    // default-parameter instance
    logic [FW-1:0] frame_data;
    logic          frame_valid;
    logic          abort;
    logic          frame_ready;
    logic          busy;
    logic          frame_done;
    logic [7:0]    drop_count;
    spi_frame_serializer_if bus ();

    spi_frame_serializer dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .i_frame_data  (frame_data),
        .i_frame_valid (frame_valid),
        .o_frame_ready (frame_ready),
        .i_abort       (abort),
        .spi           (bus),
        .o_busy        (busy),
        .o_frame_done  (frame_done),
        .o_drop_count  (drop_count)
    );

    // small MSB-first instance without checksum
    logic [31:0]   frame_data2;
    logic          frame_valid2;
    logic          abort2;
    logic          frame_ready2;
    logic          busy2;
    logic          frame_done2;
    logic [7:0]    drop_count2;
    spi_frame_serializer_if bus2 ();

    spi_frame_serializer #(
        .NUM_CHANNELS      (2),
        .BYTES_PER_CHANNEL (2),
        .MSB_FIRST         (1),
        .CHECKSUM_EN       (0)
    ) dut2 (
        .clock         (clock),
        .reset_n       (reset_n),
        .i_frame_data  (frame_data2),
        .i_frame_valid (frame_valid2),
        .o_frame_ready (frame_ready2),
        .i_abort       (abort2),
        .spi           (bus2),
        .o_busy        (busy2),
        .o_frame_done  (frame_done2),
        .o_drop_count  (drop_count2)
    );

    int total_cnt = 0;
    int bad_cnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [7:0]  exp_q[$];
    logic [31:0] words[NC];

    // Frame = cmd, address, each word LSB first, then the byte that brings
    // address + payload to zero mod 256.
    task automatic build_expected();
        int s;
        logic [7:0] b;
        s = 0;
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h00);
        for (int c = 0; c < NC; c++) begin
            for (int j = 0; j < BPC; j++) begin
                b = 8'((words[c] >> (8 * j)) & 32'hFF);
                exp_q.push_back(b);
                s = s + int'(b);
            end
        end
        exp_q.push_back(8'((256 - (s % 256)) % 256));
    endtask

    // ---------------- monitor ----------------
    int         done_cnt = 0;
    int         rise_cnt = 0;
    logic       prev_wren = 1'b0;
    logic [7:0] held = 8'h00;

    initial begin
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (bus.wren && !prev_wren) begin
                    rise_cnt++;
                    if (exp_q.size() == 0) begin
                        total_cnt++;
                        bad_cnt++;
                        $display("FAIL stray_byte: got %0h expected none at %0t", bus.tx_byte, $time);
                    end else begin
                        chk("stream_byte", {24'h0, bus.tx_byte}, {24'h0, exp_q.pop_front()});
                    end
                end else if (bus.wren && prev_wren) begin
                    chk("tx_hold", {24'h0, bus.tx_byte}, {24'h0, held});
                end
                if (frame_done) begin
                    done_cnt++;
                    chk("done_queue_empty", exp_q.size(), 0);
                end
                prev_wren = bus.wren;
            end else begin
                prev_wren = 1'b0;
            end
            held = bus.tx_byte;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic xfer(input int ack_delay);
        int t;
        if (!bus.wren) begin
            bus.di_req = 1'b1;
            t = 0;
            do begin
                @(posedge clock); #1;
                t++;
            end while (!bus.wren && t < 20);
            bus.di_req = 1'b0;
            chk("req_to_wren_latency", t, 1);
            if (!bus.wren) return;
        end
        repeat (ack_delay) begin
            @(posedge clock); #1;
        end
        bus.write_ack = 1'b1;
        @(posedge clock); #1;
        bus.write_ack = 1'b0;
    endtask

    task automatic start_frame();
        int t;
        t = 0;
        while (!frame_ready && t < 20) begin
            @(posedge clock); #1;
            t++;
        end
        chk("ready_before_start", {31'h0, frame_ready}, 1);
        for (int c = 0; c < NC; c++) frame_data[c*32 +: 32] = words[c];
        build_expected();
        frame_valid = 1'b1;
        @(posedge clock); #1;
        frame_valid = 1'b0;
    endtask

    task automatic run_bytes(input int n);
        for (int i = 0; i < n; i++) xfer(i % 3);
    endtask

    logic [7:0] lit2 [6];
    logic [7:0] got2 [6];
    int         w0;
    int         rise_base;
    int         t2;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_data   = '0;
        frame_valid  = 1'b0;
        abort        = 1'b0;
        bus.di_req   = 1'b0;
        bus.write_ack = 1'b0;
        frame_data2  = '0;
        frame_valid2 = 1'b0;
        abort2       = 1'b0;
        bus2.di_req  = 1'b0;
        bus2.write_ack = 1'b0;

        // ---- reset values ----
        repeat (3) @(posedge clock);
        #1;
        chk("rst_tx_byte", {24'h0, bus.tx_byte}, 0);
        chk("rst_wren", {31'h0, bus.wren}, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_done", {31'h0, frame_done}, 0);
        chk("rst_drop", {24'h0, drop_count}, 0);
        chk("rst_ready", {31'h0, frame_ready}, 1);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // ---- frame 1: channel c = C0DE_0000 + c ----
        for (int c = 0; c < NC; c++) words[c] = 32'hC0DE_0000 + 32'(c);
        start_frame();
        chk("model_len", exp_q.size(), TOT);
        chk("model_b0", {24'h0, exp_q[0]}, 32'h02);
        chk("model_b2", {24'h0, exp_q[2]}, 32'h00);
        chk("model_b4", {24'h0, exp_q[4]}, 32'hDE);
        chk("model_b5", {24'h0, exp_q[5]}, 32'hC0);
        chk("model_b6", {24'h0, exp_q[6]}, 32'h01);
        chk("model_csum", {24'h0, exp_q[34]}, 32'hF4);
        chk("busy_after_accept", {31'h0, busy}, 1);
        chk("ready_in_send", {31'h0, frame_ready}, 0);
        run_bytes(TOT);
        chk("done_pulse", {31'h0, frame_done}, 1);
        chk("busy_in_done", {31'h0, busy}, 0);
        @(posedge clock); #1;
        chk("done_one_cycle", {31'h0, frame_done}, 0);
        chk("ready_after_done", {31'h0, frame_ready}, 1);
        repeat (3) @(posedge clock);
        #1;
        chk("done_count_f1", done_cnt, 1);

        // ---- MSB-first small configuration ----
        lit2 = '{8'h02, 8'h00, 8'h12, 8'h34, 8'hBE, 8'hEF};
        frame_data2  = {16'hBEEF, 16'h1234};
        frame_valid2 = 1'b1;
        @(posedge clock); #1;
        frame_valid2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus2.di_req = 1'b1;
            t2 = 0;
            do begin
                @(posedge clock); #1;
                t2++;
            end while (!bus2.wren && t2 < 20);
            bus2.di_req = 1'b0;
            got2[i] = bus2.tx_byte;
            bus2.write_ack = 1'b1;
            @(posedge clock); #1;
            bus2.write_ack = 1'b0;
            if (i < 5) chk("msb_no_early_done", {31'h0, frame_done2}, 0);
        end
        chk("msb_done_after_6", {31'h0, frame_done2}, 1);
        for (int i = 0; i < 6; i++) chk("msb_stream", {24'h0, got2[i]}, {24'h0, lit2[i]});

        // ---- frame 2: drops mid-frame and held di_req ----
        for (int c = 0; c < NC; c++) words[c] = {8'(c * 17), 8'hA5, 8'(c), 8'h3C};
        start_frame();
        run_bytes(2);
        frame_data  = ~frame_data;
        frame_valid = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
        end
        frame_valid = 1'b0;
        chk("drop_three", {24'h0, drop_count}, 3);

        rise_base = rise_cnt;
        w0 = 0;
        bus.di_req = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clock); #1;
            if (w0 == 0 && bus.wren) w0 = c;
            if (w0 != 0 && c <= w0 + 5) chk("held_wren", {31'h0, bus.wren}, 1);
            if (w0 != 0 && c == w0 + 5) bus.write_ack = 1'b1;
            if (w0 != 0 && c == w0 + 8) bus.write_ack = 1'b0;
        end
        bus.di_req = 1'b0;
        bus.write_ack = 1'b0;
        chk("held_first_latency", w0, 1);
        chk("held_one_per_edge", rise_cnt - rise_base, 2);
        chk("held_pending_wren", {31'h0, bus.wren}, 1);
        @(posedge clock); #1;
        run_bytes(TOT - 3);
        repeat (3) @(posedge clock);
        #1;
        chk("done_count_f2", done_cnt, 2);

        // ---- abort after five acknowledged bytes ----
        for (int c = 0; c < NC; c++) words[c] = 32'h1357_9BDF ^ (32'(c) << 4);
        start_frame();
        run_bytes(5);
        bus.di_req = 1'b1;
        t2 = 0;
        do begin
            @(posedge clock); #1;
            t2++;
        end while (!bus.wren && t2 < 20);
        bus.di_req = 1'b0;
        chk("abort_wren_before", {31'h0, bus.wren}, 1);
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        chk("abort_wren", {31'h0, bus.wren}, 0);
        chk("abort_busy", {31'h0, busy}, 0);
        chk("abort_ready", {31'h0, frame_ready}, 1);
        chk("abort_drop_kept", {24'h0, drop_count}, 3);
        repeat (5) @(posedge clock);
        #1;
        chk("abort_no_done", done_cnt, 2);
        exp_q.delete();
        for (int c = 0; c < NC; c++) words[c] = 32'hFFFF_0000 | 32'(c * 3);
        start_frame();
        run_bytes(TOT);
        repeat (3) @(posedge clock);
        #1;
        chk("done_count_after_abort", done_cnt, 3);

        // ---- drop counter saturation ----
        for (int c = 0; c < NC; c++) words[c] = 32'h0102_0304 + 32'(c);
        start_frame();
        frame_data  = '1;
        frame_valid = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clock); #1;
            if (n == 100) chk("drop_103", {24'h0, drop_count}, 103);
            if (n == 252) chk("drop_sat_reach", {24'h0, drop_count}, 255);
        end
        frame_valid = 1'b0;
        chk("drop_saturated", {24'h0, drop_count}, 255);
        run_bytes(3);

        // ---- asynchronous reset mid-byte ----
        bus.di_req = 1'b1;
        t2 = 0;
        do begin
            @(posedge clock); #1;
            t2++;
        end while (!bus.wren && t2 < 20);
        bus.di_req = 1'b0;
        chk("pre_reset_wren", {31'h0, bus.wren}, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_tx_byte", {24'h0, bus.tx_byte}, 0);
        chk("arst_wren", {31'h0, bus.wren}, 0);
        chk("arst_busy", {31'h0, busy}, 0);
        chk("arst_done", {31'h0, frame_done}, 0);
        chk("arst_drop", {24'h0, drop_count}, 0);
        chk("arst_ready", {31'h0, frame_ready}, 1);
        exp_q.delete();
        @(posedge clock);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        for (int c = 0; c < NC; c++) words[c] = 32'hDEAD_BEEF - 32'(c * 7);
        start_frame();
        run_bytes(TOT);
        repeat (3) @(posedge clock);
        #1;
        chk("done_count_after_reset", done_cnt, 4);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule : tb_spi_frame_serializer
`default_nettype wire
